// File: rtl/video_pkg.sv
// Shared types for the video mode controller: resolution codes,
// window table, register addresses and controller states.
package video_pkg;

  typedef enum logic [1:0] {
    RES_256X192 = 2'd0,
    RES_320X200 = 2'd1,
    RES_320X240 = 2'd2,
    RES_360X288 = 2'd3
  } res_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_SETTLE = 2'd2
  } vstate_e;

  localparam logic [1:0] ADDR_VCONFIG = 2'd0;
  localparam logic [1:0] ADDR_HINT    = 2'd1;
  localparam logic [1:0] ADDR_VINT_L  = 2'd2;
  localparam logic [1:0] ADDR_VINT_H  = 2'd3;

  typedef struct packed {
    logic [8:0] hbeg;
    logic [8:0] hend;
    logic [8:0] vbeg;
    logic [8:0] vend;
  } win_t;

  localparam win_t WIN_256X192 = '{
    hbeg: 9'd140, hend: 9'd396,
    vbeg: 9'd80,  vend: 9'd272
  };
  localparam win_t WIN_320X200 = '{
    hbeg: 9'd108, hend: 9'd428,
    vbeg: 9'd76,  vend: 9'd276
  };
  localparam win_t WIN_320X240 = '{
    hbeg: 9'd108, hend: 9'd428,
    vbeg: 9'd56,  vend: 9'd296
  };
  localparam win_t WIN_360X288 = '{
    hbeg: 9'd88,  hend: 9'd448,
    vbeg: 9'd32,  vend: 9'd320
  };

endpackage

// File: rtl/video_mode_ctrl_if.sv
// CPU register write bus into the video mode controller.
interface video_mode_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/video_res_lut.sv
// Resolution code to pixel window lookup, in hcount units.
module video_res_lut
  import video_pkg::*;
(
  input  logic [1:0] rres,
  output win_t       win
);

  always_comb begin
    win = WIN_256X192;
    unique case (res_e'(rres))
      RES_256X192: win = WIN_256X192;
      RES_320X200: win = WIN_320X200;
      RES_320X240: win = WIN_320X240;
      RES_360X288: win = WIN_360X288;
    endcase
  end

endmodule

// File: rtl/video_mode_ctrl.sv
// Shadow/commit controller for raster video parameters with a
// post-resolution-change graphics mute window.
module video_mode_ctrl
  import video_pkg::*;
#(
  parameter int unsigned SETTLE_FRAMES = 1,
  parameter logic [1:0]  RES_DEFAULT   = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_stb,
  video_mode_ctrl_if.slave cpu,
  output logic [8:0] hpix_beg,
  output logic [8:0] hpix_end,
  output logic [8:0] vpix_beg,
  output logic [8:0] vpix_end,
  output logic [8:0] hpix_beg_ts,
  output logic [8:0] hpix_end_ts,
  output logic [8:0] vpix_beg_ts,
  output logic [8:0] vpix_end_ts,
  output logic [7:0] hint_beg,
  output logic [8:0] vint_beg,
  output logic       nogfx,
  output logic       pending,
  output logic       settling
);

  localparam logic [2:0] CNT_LOAD = 3'(SETTLE_FRAMES);

  logic [1:0] sh_rres_q, sh_rres_d;
  logic       sh_nogfx_q, sh_nogfx_d;
  logic [7:0] sh_hint_q, sh_hint_d;
  logic [8:0] sh_vint_q, sh_vint_d;
  logic [1:0] cm_rres_q, cm_rres_d;
  logic       cm_nogfx_q, cm_nogfx_d;
  logic [7:0] cm_hint_q, cm_hint_d;
  logic [8:0] cm_vint_q, cm_vint_d;
  logic       pend_q, pend_d;
  logic [2:0] cnt_q, cnt_d;
  vstate_e    state_q, state_d;
  logic       commit;
  logic       res_chg;
  win_t       win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_rres_q  <= RES_DEFAULT;
      sh_nogfx_q <= 1'b0;
      sh_hint_q  <= '0;
      sh_vint_q  <= '0;
      cm_rres_q  <= RES_DEFAULT;
      cm_nogfx_q <= 1'b0;
      cm_hint_q  <= '0;
      cm_vint_q  <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      state_q    <= ST_IDLE;
    end else begin
      sh_rres_q  <= sh_rres_d;
      sh_nogfx_q <= sh_nogfx_d;
      sh_hint_q  <= sh_hint_d;
      sh_vint_q  <= sh_vint_d;
      cm_rres_q  <= cm_rres_d;
      cm_nogfx_q <= cm_nogfx_d;
      cm_hint_q  <= cm_hint_d;
      cm_vint_q  <= cm_vint_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    sh_rres_d  = sh_rres_q;
    sh_nogfx_d = sh_nogfx_q;
    sh_hint_d  = sh_hint_q;
    sh_vint_d  = sh_vint_q;
    cm_rres_d  = cm_rres_q;
    cm_nogfx_d = cm_nogfx_q;
    cm_hint_d  = cm_hint_q;
    cm_vint_d  = cm_vint_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    state_d    = state_q;

    // Commit always takes the pre-write shadow.
    commit  = frame_stb && pend_q;
    res_chg = commit && (sh_rres_q != cm_rres_q);

    if (commit) begin
      cm_rres_d  = sh_rres_q;
      cm_nogfx_d = sh_nogfx_q;
      cm_hint_d  = sh_hint_q;
      cm_vint_d  = sh_vint_q;
    end

    if (cpu.wr_en) begin
      unique case (cpu.wr_addr)
        ADDR_VCONFIG: begin
          sh_rres_d  = cpu.wr_data[1:0];
          sh_nogfx_d = cpu.wr_data[5];
        end
        ADDR_HINT:   sh_hint_d = cpu.wr_data;
        ADDR_VINT_L: sh_vint_d[7:0] = cpu.wr_data;
        ADDR_VINT_H: sh_vint_d[8] = cpu.wr_data[0];
      endcase
    end

    if (commit) pend_d = cpu.wr_en;
    else if (cpu.wr_en) pend_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu.wr_en) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (res_chg) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_LOAD;
        end else if (commit) begin
          state_d = pend_d ? ST_PEND : ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (res_chg) begin
          cnt_d = CNT_LOAD;
        end else if (frame_stb) begin
          if (cnt_q <= 3'd1) begin
            cnt_d   = '0;
            state_d = pend_d ? ST_PEND : ST_IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  video_res_lut u_lut (
    .rres (cm_rres_q),
    .win  (win)
  );

  assign hpix_beg    = win.hbeg;
  assign hpix_end    = win.hend;
  assign vpix_beg    = win.vbeg;
  assign vpix_end    = win.vend;
  assign hpix_beg_ts = win.hbeg;
  assign hpix_end_ts = win.hend;
  assign vpix_beg_ts = win.vbeg;
  assign vpix_end_ts = win.vend;
  assign hint_beg    = cm_hint_q;
  assign vint_beg    = cm_vint_q;
  assign settling    = (state_q == ST_SETTLE);
  assign pending     = pend_q;
  assign nogfx       = cm_nogfx_q | settling;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomized bench for video_mode_ctrl against a frame-level
// reference model of shadow/commit/settle behaviour.
module tb_video_mode_ctrl;

  localparam int N_SETTLE = 3;

  logic       clk;
  logic       rst_n;
  logic       frame_stb;
  logic [8:0] hpix_beg, hpix_end, vpix_beg, vpix_end;
  logic [8:0] hpix_beg_ts, hpix_end_ts, vpix_beg_ts, vpix_end_ts;
  logic [7:0] hint_beg;
  logic [8:0] vint_beg;
  logic       nogfx, pending, settling;

  int n_cmp;
  int n_bad;

  video_mode_ctrl_if bus ();

  video_mode_ctrl #(
    .SETTLE_FRAMES (N_SETTLE),
    .RES_DEFAULT   (2'd0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_stb   (frame_stb),
    .cpu         (bus.slave),
    .hpix_beg    (hpix_beg),
    .hpix_end    (hpix_end),
    .vpix_beg    (vpix_beg),
    .vpix_end    (vpix_end),
    .hpix_beg_ts (hpix_beg_ts),
    .hpix_end_ts (hpix_end_ts),
    .vpix_beg_ts (vpix_beg_ts),
    .vpix_end_ts (vpix_end_ts),
    .hint_beg    (hint_beg),
    .vint_beg    (vint_beg),
    .nogfx       (nogfx),
    .pending     (pending),
    .settling    (settling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Resolution table, indexed [rres][hbeg,hend,vbeg,vend].
  int tbl [4][4] = '{
    '{140, 396, 80, 272},
    '{108, 428, 76, 276},
    '{108, 428, 56, 296},
    '{ 88, 448, 32, 320}
  };

  // Reference model: shadow, committed, pending flag, frames left.
  int m_s_res, m_s_ng, m_s_hint, m_s_vint;
  int m_c_res, m_c_ng, m_c_hint, m_c_vint;
  int m_pend;
  int m_left;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_s_res = 0; m_s_ng = 0; m_s_hint = 0; m_s_vint = 0;
    m_c_res = 0; m_c_ng = 0; m_c_hint = 0; m_c_vint = 0;
    m_pend = 0;
    m_left = 0;
  endtask

  task automatic mdl_edge(input bit w, input int a, input int d,
                          input bit s);
    bit cm;
    cm = s && (m_pend != 0);
    if (cm) begin
      if (m_s_res != m_c_res) m_left = N_SETTLE;
      else if (m_left > 0) m_left--;
      m_c_res = m_s_res; m_c_ng = m_s_ng;
      m_c_hint = m_s_hint; m_c_vint = m_s_vint;
    end else if (s && m_left > 0) begin
      m_left--;
    end
    if (w) begin
      case (a)
        0: begin m_s_res = d % 4; m_s_ng = (d / 32) % 2; end
        1: m_s_hint = d;
        2: m_s_vint = (m_s_vint / 256) * 256 + d;
        default: m_s_vint = (m_s_vint % 256) + 256 * (d % 2);
      endcase
    end
    if (cm) m_pend = w;
    else if (w) m_pend = 1;
  endtask

  task automatic check_all();
    int st;
    st = (m_left > 0) ? 1 : 0;
    chk("hbeg", hpix_beg, tbl[m_c_res][0]);
    chk("hend", hpix_end, tbl[m_c_res][1]);
    chk("vbeg", vpix_beg, tbl[m_c_res][2]);
    chk("vend", vpix_end, tbl[m_c_res][3]);
    chk("hbeg_ts", hpix_beg_ts, tbl[m_c_res][0]);
    chk("hend_ts", hpix_end_ts, tbl[m_c_res][1]);
    chk("vbeg_ts", vpix_beg_ts, tbl[m_c_res][2]);
    chk("vend_ts", vpix_end_ts, tbl[m_c_res][3]);
    chk("hint", hint_beg, m_c_hint);
    chk("vint", vint_beg, m_c_vint);
    chk("settling", settling, st);
    chk("nogfx", nogfx, (m_c_ng != 0 || st != 0) ? 1 : 0);
    chk("pending", pending, m_pend);
  endtask

  task automatic cyc(input bit w, input int a, input int d,
                     input bit s);
    bus.wr_en   = w;
    bus.wr_addr = 2'(a);
    bus.wr_data = 8'(d);
    frame_stb   = s;
    @(posedge clk);
    mdl_edge(w, a, d, s);
    #1;
    bus.wr_en = 1'b0;
    frame_stb = 1'b0;
    check_all();
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    frame_stb = 1'b0;
    rst_n = 1'b0;
    mdl_reset();
    #12;
    chk("rst_hbeg", hpix_beg, 140);
    chk("rst_vend", vpix_end, 272);
    chk("rst_nogfx", nogfx, 0);
    chk("rst_pend", pending, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Resolution change and settle window.
    cyc(1, 0, 8'h03, 0);
    chk("t2_pend", pending, 1);
    cyc(0, 0, 0, 1);
    chk("t2_hbeg", hpix_beg, 88);
    chk("t2_hend", hpix_end, 448);
    chk("t2_settle", settling, 1);
    for (int i = 0; i < N_SETTLE + 1; i++) begin
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
    end
    chk("t2_done", settling, 0);

    // HINT/VINT commit, no settle.
    cyc(1, 1, 8'h40, 0);
    cyc(1, 2, 8'h10, 0);
    cyc(1, 3, 8'h01, 0);
    chk("t3_hold", hint_beg, 0);
    cyc(0, 0, 0, 1);
    chk("t3_hint", hint_beg, 'h40);
    chk("t3_vint", vint_beg, 'h110);
    chk("t3_nosettle", settling, 0);

    // Write coincident with frame strobe.
    cyc(1, 1, 8'h55, 0);
    cyc(1, 0, 8'h01, 1);
    chk("t4_pend", pending, 1);
    chk("t4_old", hpix_beg, 88);
    cyc(0, 0, 0, 1);
    chk("t4_new", vpix_beg, 76);

    // Reload during settle.
    cyc(0, 0, 0, 1);
    cyc(1, 0, 8'h02, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < N_SETTLE; i++) begin
      chk("t5_hold", settling, 1);
      cyc(0, 0, 0, 1);
    end
    chk("t5_done", settling, 0);

    // Reset while pending.
    cyc(1, 0, 8'h03, 0);
    async_reset();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
